// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI4-Stream packetizer.
// The framing FSM state enum and the skid-buffer depth live here.
package axis_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry skid buffer with fully registered outputs (data, valid, ready).
// Entry 0 is the output register; entry 1 absorbs the beat accepted while the output is stalled.
module axis_skid_buffer
  import axis_pkg::*;
#(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  // Handshake: a beat moves on a port when valid and ready are both 1 at a rising
  // edge; once out_valid is 1, out_data/out_valid hold until out_ready takes the beat.

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);

  logic [WIDTH-1:0] skid_data, skid_data_n, out_data_n;
  logic             skid_valid, skid_valid_n, out_valid_n;
  logic             push, pop;
  logic [OCC_W-1:0] occ_n;

  always_comb begin
    push         = in_valid && in_ready;
    pop          = out_valid && out_ready;
    out_valid_n  = out_valid;
    out_data_n   = out_data;
    skid_valid_n = skid_valid;
    skid_data_n  = skid_data;
    if (!out_valid || pop) begin
      if (skid_valid) begin
        out_valid_n  = 1'b1;
        out_data_n   = skid_data;
        skid_valid_n = push;
        if (push) skid_data_n = in_data;
      end else begin
        out_valid_n = push;
        if (push) out_data_n = in_data;
      end
    end else if (push) begin
      skid_valid_n = 1'b1;
      skid_data_n  = in_data;
    end
    occ_n = OCC_W'(out_valid_n) + OCC_W'(skid_valid_n);
  end

  // in_ready is registered from the next occupancy so it drops only when both entries fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b0;
    end else begin
      out_valid  <= out_valid_n;
      out_data   <= out_data_n;
      skid_valid <= skid_valid_n;
      skid_data  <= skid_data_n;
      in_ready   <= (occ_n != OCC_W'(SKID_DEPTH));
    end
  end

endmodule

// File: rtl/axis_packetizer.sv
// Frames an unframed AXI4-Stream into packets of pkt_len beats by generating tlast,
// then drives the result through a registered skid buffer; counts completed packets.
module axis_packetizer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int LEN_WIDTH   = 8,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [DATA_WIDTH-1:0]  in_tdata,
  input  logic                   in_tvalid,
  output logic                   in_tready,
  output logic [DATA_WIDTH-1:0]  out_tdata,
  output logic                   out_tvalid,
  output logic                   out_tlast,
  input  logic                   out_tready,
  input  logic [LEN_WIDTH-1:0]   pkt_len,
  output logic [COUNT_WIDTH-1:0] pkt_count,
  output logic                   busy
);

  // resetn is active-high: resetn=1 holds the whole block in reset.
  state_t               state, state_n;
  logic [LEN_WIDTH-1:0] beat_cnt, beat_cnt_n;
  logic [LEN_WIDTH-1:0] len_q, len_n;
  logic [LEN_WIDTH-1:0] eff_len;
  logic                 in_xfer;
  logic                 tag_last;

  assign in_xfer = in_tvalid && in_tready;
  assign eff_len = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
  assign busy    = (state == STREAM);

  always_comb begin
    state_n    = state;
    beat_cnt_n = beat_cnt;
    len_n      = len_q;
    tag_last   = 1'b0;
    case (state)
      IDLE: begin
        if (in_xfer) begin
          // Single-beat packets never leave IDLE.
          if (eff_len == LEN_WIDTH'(1)) begin
            tag_last = 1'b1;
          end else begin
            len_n      = eff_len;
            beat_cnt_n = LEN_WIDTH'(1);
            state_n    = STREAM;
          end
        end
      end
      STREAM: begin
        if (in_xfer) begin
          if (LEN_WIDTH'(beat_cnt + 1'b1) == len_q) begin
            tag_last   = 1'b1;
            beat_cnt_n = '0;
            state_n    = IDLE;
          end else begin
            beat_cnt_n = LEN_WIDTH'(beat_cnt + 1'b1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= IDLE;
      beat_cnt <= '0;
      len_q    <= '0;
    end else begin
      state    <= state_n;
      beat_cnt <= beat_cnt_n;
      len_q    <= len_n;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      pkt_count <= '0;
    end else if (out_tvalid && out_tready && out_tlast) begin
      pkt_count <= pkt_count + 1'b1;
    end
  end

  axis_skid_buffer #(
    .WIDTH(DATA_WIDTH + 1)
  ) u_skid (
    .clk      (clk),
    .rst      (resetn),
    .in_data  ({tag_last, in_tdata}),
    .in_valid (in_tvalid),
    .in_ready (in_tready),
    .out_data ({out_tlast, out_tdata}),
    .out_valid(out_tvalid),
    .out_ready(out_tready)
  );

endmodule

// File: tb/tb_axis_packetizer.sv
// Directed and randomized bench for axis_packetizer with a packet-level reference model.
module tb_axis_packetizer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] in_tdata;
  logic        in_tvalid;
  logic        in_tready;
  logic [15:0] out_tdata;
  logic        out_tvalid;
  logic        out_tlast;
  logic        out_tready = 1'b0;
  logic [7:0]  pkt_len;
  logic [15:0] pkt_count;
  logic        busy;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_pkts = 0;
  int          ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic [16:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [16:0] prev_beat;

  axis_packetizer dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_tdata  (in_tdata),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tvalid(out_tvalid),
    .out_tlast (out_tlast),
    .out_tready(out_tready),
    .pkt_len   (pkt_len),
    .pkt_count (pkt_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_tready = 1'b1;
      1:       out_tready = 1'($urandom_range(0, 1));
      default: out_tready = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Output monitor: scoreboard against exp_q and hold-while-stalled check.
  always @(negedge clk) begin
    if (resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(out_tvalid), 32'd1);
        chk("hold_beat", 32'({out_tlast, out_tdata}), 32'(prev_beat));
      end
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("out_beat", 32'({out_tlast, out_tdata}), 32'(e));
        end
      end
      prev_stall = out_tvalid && !out_tready;
      prev_beat  = {out_tlast, out_tdata};
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [15:0] d, input logic [7:0] len, input logic last);
    bit done;
    done      = 1'b0;
    in_tvalid = 1'b1;
    in_tdata  = d;
    pkt_len   = len;
    for (int i = 0; i < 64 && !done; i++) begin
      done = in_tready;
      @(posedge clk);
      if (done) begin
        exp_q.push_back({last, d});
        if (last) exp_pkts++;
      end
      @(negedge clk);
    end
    chk("in_accept", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    in_tvalid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Reference framing: a packet of field value len is max(len,1) beats, last one tagged.
  // Mid-packet, pkt_len is driven with junk, which must not affect framing.
  task automatic send_packet(input logic [7:0] len, input logic [15:0] base, input bit junk);
    int l;
    l = (len == 0) ? 1 : int'(len);
    for (int i = 0; i < l; i++)
      send_beat(base + 16'(i), (i == 0 || !junk) ? len : 8'($urandom), i == l - 1);
  endtask

  task automatic drain(input string tag);
    int n;
    in_tvalid = 1'b0;
    n = 0;
    while (n < 400 && (exp_q.size() != 0 || out_tvalid)) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_pkt_count"}, 32'(pkt_count), 32'(exp_pkts & 16'hFFFF));
  endtask

  initial begin
    resetn    = 1'b1;
    in_tvalid = 1'b0;
    in_tdata  = '0;
    pkt_len   = 8'd4;
    repeat (3) @(negedge clk);
    chk("rst_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("rst_out_tlast", 32'(out_tlast), 32'd0);
    chk("rst_out_tdata", 32'(out_tdata), 32'd0);
    chk("rst_in_tready", 32'(in_tready), 32'd0);
    chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    resetn = 1'b0;
    @(negedge clk);
    chk("post_rst_in_tready", 32'(in_tready), 32'd1);

    // pkt_len=4, 12 beats, always ready: one-cycle latency, tlast every 4th.
    for (int i = 0; i < 12; i++) begin
      send_beat(16'(i), 8'd4, (i % 4) == 3);
      chk("lat_valid", 32'(out_tvalid), 32'd1);
      chk("lat_beat", 32'({out_tlast, out_tdata}), {15'd0, 1'((i % 4) == 3), 16'(i)});
      if (i == 0) chk("busy_in_packet", 32'(busy), 32'd1);
    end
    drain("len4");

    // pkt_len=0 behaves as single-beat packets and never enters STREAM.
    for (int i = 0; i < 3; i++) begin
      send_beat(16'h0100 + 16'(i), 8'd0, 1'b1);
      chk("len0_busy", 32'(busy), 32'd0);
    end
    drain("len0");

    // pkt_len=3 with a stalled output: buffer fills after two beats.
    send_beat(16'h0200, 8'd3, 1'b0);
    drain("stall_pre");
    chk("stall_busy", 32'(busy), 32'd1);
    ready_mode = 2;
    idle(2);
    send_beat(16'h0201, 8'd9, 1'b0);
    send_beat(16'h0202, 8'd9, 1'b1);
    in_tdata = 16'h0203;
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_tready", 32'(in_tready), 32'd0);
      chk("stall_out_data", 32'(out_tdata), 32'h0201);
      @(negedge clk);
    end
    ready_mode = 0;
    send_beat(16'h0203, 8'd3, 1'b0);
    send_beat(16'h0204, 8'd7, 1'b0);
    send_beat(16'h0205, 8'd7, 1'b1);
    drain("stall");

    // pkt_len changes from 2 to 5 after the first beat.
    send_beat(16'h0300, 8'd2, 1'b0);
    send_beat(16'h0301, 8'd5, 1'b1);
    for (int i = 0; i < 5; i++) send_beat(16'h0302 + 16'(i), 8'd5, i == 4);
    drain("len_change");

    // Reset in mid-packet with beats buffered.
    ready_mode = 2;
    idle(2);
    send_beat(16'h0400, 8'd4, 1'b0);
    send_beat(16'h0401, 8'd4, 1'b0);
    in_tvalid = 1'b0;
    resetn    = 1'b1;
    @(negedge clk);
    exp_q.delete();
    exp_pkts = 0;
    chk("mid_rst_out_tvalid", 32'(out_tvalid), 32'd0);
    chk("mid_rst_out_tlast", 32'(out_tlast), 32'd0);
    chk("mid_rst_out_tdata", 32'(out_tdata), 32'd0);
    chk("mid_rst_in_tready", 32'(in_tready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pkt_count", 32'(pkt_count), 32'd0);
    ready_mode = 0;
    resetn     = 1'b0;
    @(negedge clk);
    send_packet(8'd4, 16'h0500, 1'b0);
    drain("after_rst");

    // Randomized: random out_tready, random input gaps, pkt_len=16.
    ready_mode = 1;
    for (int i = 0; i < 64; i++) begin
      idle($urandom_range(0, 2));
      send_beat(16'($urandom), 8'd16, (i % 16) == 15);
    end
    drain("rand16");

    // Randomized lengths with junk on pkt_len mid-packet.
    for (int p = 0; p < 12; p++) begin
      idle($urandom_range(0, 1));
      send_packet(8'($urandom_range(0, 6)), 16'($urandom), 1'b1);
    end
    drain("rand_len");

    ready_mode = 0;
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of tdata on both streams.
REQ-002 Parameter LEN_WIDTH, default 8: width of the packet-length input and the beat counter.
REQ-003 Parameter COUNT_WIDTH, default 16: width of the packet counter.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 resetn  input  1  synchronous reset, active-high despite the name: resetn=1 resets the block.
REQ-006 in  AXI4S slave port  DATA_WIDTH  unframed beats from the upstream AXISFIFO; uses tdata, tvalid and tready; incoming tlast is ignored.
REQ-007 out  AXI4S master port  DATA_WIDTH  framed beats; drives tdata, tvalid and tlast, and samples tready.
REQ-008 pkt_len  input  LEN_WIDTH  beats per packet, sampled at each packet start.
REQ-009 pkt_count  output  COUNT_WIDTH  number of packets completed on out.
REQ-010 busy  output  1  high while the state machine is in STREAM.

Function
REQ-011 A transfer occurs on a port when tvalid and tready are both 1 on a rising edge.
REQ-012 Data SHALL pass in order, unmodified, with no loss and no duplication.
REQ-013 Latency from an in transfer to that beat appearing on out.tvalid SHALL be exactly 1 cycle when out is not stalled.
REQ-014 out.tdata, out.tvalid and out.tlast SHALL be registered outputs.
REQ-015 in.tready SHALL be registered, and SHALL be low only when the 2-entry skid buffer is full.
REQ-016 Sustained throughput SHALL be 1 beat/cycle while out.tready is held at 1.
REQ-017 Once out.tvalid is 1, out.tdata, out.tvalid and out.tlast SHALL stay stable until the beat is transferred.
REQ-018 The state machine SHALL have two states: IDLE and STREAM.
REQ-019 IDLE -> STREAM on the first in transfer.
  - pkt_len is latched as the length L in the same cycle.
  - pkt_len=0 is treated as L=1.
REQ-020 In STREAM, the beat counter increments on each in transfer.
  - The beat that makes the count equal L is tagged tlast=1.
  - The counter then clears and the state returns to IDLE.
REQ-021 For L=1, every beat SHALL carry tlast=1, and the state SHALL remain IDLE with no STREAM cycle.
REQ-022 A change on pkt_len mid-packet SHALL have no effect until the next packet start.
REQ-023 When the last beat of a packet transfers and a new in transfer arrives in the same cycle, the new beat SHALL start the next packet with pkt_len sampled that cycle.
REQ-024 pkt_count SHALL increment by 1 on each out transfer with tlast=1, and SHALL wrap from 2^COUNT_WIDTH-1 to 0.
REQ-025 When out.tready=0, beats SHALL be held in the skid buffer.
  - in.tready falls within the cycle after the buffer fills.
  - No beat is dropped.
REQ-026 A simultaneous skid-buffer push and pop SHALL keep the occupancy unchanged.

Reset
REQ-027 On resetn=1, the block SHALL set:
  - state = IDLE, beat counter = 0, skid buffer empty;
  - out.tvalid = 0, out.tlast = 0, out.tdata = 0;
  - in.tready = 0, pkt_count = 0, busy = 0.
REQ-028 In the first cycle after resetn falls, in.tready SHALL be 1.
REQ-029 A reset during a packet SHALL discard the partial packet and all buffered beats, and the next beat SHALL start a new packet.

Structure
REQ-030 Shared package axis_pkg SHALL hold:
  - the state enum (IDLE, STREAM);
  - a localparam for skid depth (2).
REQ-031 Sub-module axis_skid_buffer, parameterised by DATA_WIDTH+1 to carry {tlast, tdata}, SHALL implement REQ-014 to REQ-017 and REQ-025/026.
REQ-032 The framing FSM and counters SHALL sit in axis_packetizer, ahead of the skid buffer.

Verification
REQ-033 pkt_len=4, 12 beats 0x0000..0x000B, out.tready=1:
  - tlast on 0x0003, 0x0007 and 0x000B;
  - pkt_count=3;
  - each beat on out 1 cycle after in.
REQ-034 pkt_len=0, 3 beats -> each beat has tlast=1, pkt_count=3, busy stays 0.
REQ-035 pkt_len=3, out.tready=0 for 5 cycles during streaming:
  - in.tready drops after 2 beats are buffered;
  - on release, the sequence resumes with no gap, loss or duplicate.
REQ-036 pkt_len=2, change pkt_len to 5 after beat 1 -> tlast on beat 2, then the next packet is 5 beats long.
REQ-037 resetn=1 pulse after 2 beats of a pkt_len=4 packet:
  - all outputs return to reset values;
  - the next 4 beats form one complete packet with tlast on the 4th.
REQ-038 Chain with AXISFIFO using the fifo.hex source and comparator:
  - randomized out.tready;
  - pkt_len=16;
  - the data matches the reference and pkt_count equals beats/16.
